// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 8-bit processor.
// The FSM steps through FETCH -> DECODE -> EXEC -> (MEM -> (WB)) and drives the
// datapath controls and memory req/ack handshake from registered state.
// Optional macro CU_TRAP_EN: when defined, an illegal opcode parks the FSM in
// TRAP until reset. When undefined, it executes as a NOP with a one-cycle
// illegal pulse.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned INSTR_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_ld,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic                J,
    output logic                JC,
    output logic                INA,
    output logic                RM,
    output logic                WM,
    output logic                SIN,
    output logic                SOUT,
    output logic                WR,
    output logic                NEQ,
    output logic [OPCODE_W-1:0] opcode,
    output logic                illegal,
    output logic [2:0]          state
);

`ifdef CU_TRAP_EN
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;
`endif

    state_t              r_state;
    logic [OPCODE_W-1:0] r_opcode;
    logic                r_mem_req, r_mem_we, r_pc_inc, r_pc_ld;
    logic                r_j, r_jc, r_ina, r_rm, r_wm, r_sin, r_sout, r_wr, r_neq;
    logic                r_illegal;

    logic       w_op_illegal;
    logic [2:0] w_op3;
    logic       w_is_mw;
    logic       w_is_mr;
    logic       w_mw_done;
    logic       w_unused_instr;

    // Opcodes of value 8 or more exist only when the field is wider than 3 bits.
    generate
        if (OPCODE_W > 3) begin : g_wide_op
            assign w_op_illegal = |r_opcode[OPCODE_W-1:3];
        end else begin : g_narrow_op
            assign w_op_illegal = 1'b0;
        end
    endgenerate

    assign w_op3          = r_opcode[2:0];
    assign w_is_mw        = ~w_op_illegal & (w_op3 == 3'b010);
    assign w_is_mr        = ~w_op_illegal & (w_op3 == 3'b011);
    assign w_unused_instr = ^instr;

    // Outputs are registered alongside the state they belong to. The MW
    // completion pulse must land in the ack cycle, so like ir_ld it is
    // qualified by mem_ack.
    assign w_mw_done = (r_state == ST_MEM) & w_is_mw & mem_ack;

    assign ir_ld   = (r_state == ST_FETCH) & mem_ack;
    assign pc_inc  = r_pc_inc | w_mw_done;
    assign mem_req = r_mem_req;
    assign mem_we  = r_mem_we;
    assign pc_ld   = r_pc_ld;
    assign J       = r_j;
    assign JC      = r_jc;
    assign INA     = r_ina;
    assign RM      = r_rm;
    assign WM      = r_wm;
    assign SIN     = r_sin;
    assign SOUT    = r_sout;
    assign WR      = r_wr;
    assign NEQ     = r_neq;
    assign opcode  = r_opcode;
    assign illegal = r_illegal;
    assign state   = r_state;

    // FSM: next state plus the control outputs that belong to that next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_opcode  <= '0;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_pc_ld   <= 1'b0;
            r_j       <= 1'b0;
            r_jc      <= 1'b0;
            r_ina     <= 1'b0;
            r_rm      <= 1'b0;
            r_wm      <= 1'b0;
            r_sin     <= 1'b0;
            r_sout    <= 1'b0;
            r_wr      <= 1'b0;
            r_neq     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_pc_ld   <= 1'b0;
            r_j       <= 1'b0;
            r_jc      <= 1'b0;
            r_ina     <= 1'b0;
            r_rm      <= 1'b0;
            r_wm      <= 1'b0;
            r_sin     <= 1'b0;
            r_sout    <= 1'b0;
            r_wr      <= 1'b0;
            r_neq     <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        r_opcode <= instr[INSTR_W-1 -: OPCODE_W];
                        r_state  <= ST_DECODE;
                    end else begin
                        r_mem_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
`ifdef CU_TRAP_EN
                    if (w_op_illegal) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end else
`endif
                    begin
                        r_state <= ST_EXEC;
                        if (w_op_illegal) begin
                            r_pc_inc  <= 1'b1;
                            r_illegal <= 1'b1;
                        end else begin
                            case (w_op3)
                                3'b000: begin r_sout <= 1'b1; r_pc_inc <= 1'b1; end
                                3'b001: begin r_ina <= 1'b1; r_sin <= 1'b1; r_pc_inc <= 1'b1; end
                                3'b010: r_wm <= 1'b1;
                                3'b011: r_rm <= 1'b1;
                                3'b100: begin r_j <= 1'b1; r_pc_ld <= 1'b1; end
                                3'b101: begin
                                    r_jc     <= 1'b1;
                                    r_pc_ld  <= zero;
                                    r_pc_inc <= ~zero;
                                end
                                3'b110: begin r_wr <= 1'b1; r_pc_inc <= 1'b1; end
                                3'b111: begin
                                    r_jc     <= 1'b1;
                                    r_neq    <= 1'b1;
                                    r_pc_ld  <= ~zero;
                                    r_pc_inc <= zero;
                                end
                            endcase
                        end
                    end
                end
                ST_EXEC: begin
                    r_mem_req <= 1'b1;
                    if (w_is_mw || w_is_mr) begin
                        r_state  <= ST_MEM;
                        r_mem_we <= w_is_mw;
                        r_wm     <= w_is_mw;
                        r_rm     <= w_is_mr;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (w_is_mw) begin
                            r_state   <= ST_FETCH;
                            r_mem_req <= 1'b1;
                        end else begin
                            r_state  <= ST_WB;
                            r_wr     <= 1'b1;
                            r_rm     <= 1'b1;
                            r_pc_inc <= 1'b1;
                        end
                    end else begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= w_is_mw;
                        r_wm      <= w_is_mw;
                        r_rm      <= w_is_mr;
                    end
                end
                ST_WB: begin
                    r_state   <= ST_FETCH;
                    r_mem_req <= 1'b1;
                end
`ifdef CU_TRAP_EN
                ST_TRAP: begin
                    r_illegal <= 1'b1;
                end
`endif
                default: begin
                    r_state   <= ST_FETCH;
                    r_mem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (OPCODE_W=4 so that
// illegal opcodes are reachable). Expected per-cycle outputs come from an
// instruction-level model that expands each instruction into its cycle trace.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

    localparam int unsigned C_REQ  = 14;
    localparam int unsigned C_WE   = 13;
    localparam int unsigned C_IRLD = 12;
    localparam int unsigned C_INC  = 11;
    localparam int unsigned C_LD   = 10;
    localparam int unsigned C_J    = 9;
    localparam int unsigned C_JC   = 8;
    localparam int unsigned C_INA  = 7;
    localparam int unsigned C_RM   = 6;
    localparam int unsigned C_WM   = 5;
    localparam int unsigned C_SIN  = 4;
    localparam int unsigned C_SOUT = 3;
    localparam int unsigned C_WR   = 2;
    localparam int unsigned C_NEQ  = 1;
    localparam int unsigned C_ILL  = 0;

`ifdef CU_TRAP_EN
    localparam bit TRAP_BUILD = 1'b1;
`else
    localparam bit TRAP_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] instr = '0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, ir_ld, pc_inc, pc_ld;
    logic       J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ;
    logic [3:0] opcode;
    logic       illegal;
    logic [2:0] state;

    typedef struct {
        logic        ack;
        logic [7:0]  ins;
        logic        z;
        logic [21:0] exp;
    } cyc_t;

    cyc_t       q[$];
    logic [3:0] m_op = 4'd0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPCODE_W(4), .INSTR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
        .J(J), .JC(JC), .INA(INA), .RM(RM), .WM(WM), .SIN(SIN), .SOUT(SOUT), .WR(WR),
        .NEQ(NEQ), .opcode(opcode), .illegal(illegal), .state(state)
    );

    function automatic logic [21:0] obs();
        return {state, opcode, mem_req, mem_we, ir_ld, pc_inc, pc_ld, J, JC, INA,
                RM, WM, SIN, SOUT, WR, NEQ, illegal};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom);
    endfunction

    function automatic void add_cyc(input logic ack, input logic [7:0] ins, input logic z,
                                    input logic [2:0] st, input logic [14:0] c);
        cyc_t r;
        r.ack = ack;
        r.ins = ins;
        r.z   = z;
        r.exp = {st, m_op, c};
        q.push_back(r);
    endfunction

    // FETCH cycles with no ack: only mem_req is expected.
    function automatic void model_idle(input int unsigned n);
        logic [14:0] c;
        c = '0;
        c[C_REQ] = 1'b1;
        for (int unsigned i = 0; i < n; i++) add_cyc(1'b0, rbyte(), zero, 3'd0, c);
    endfunction

    // One instruction: fw fetch wait cycles, mw memory wait cycles.
    function automatic void model_instr(input logic [3:0] op, input logic z,
                                        input int unsigned fw, input int unsigned mw);
        logic [14:0] c;
        c = '0;
        c[C_REQ] = 1'b1;
        for (int unsigned i = 0; i < fw; i++) add_cyc(1'b0, rbyte(), z, 3'd0, c);
        c[C_IRLD] = 1'b1;
        add_cyc(1'b1, {op, 4'($urandom)}, z, 3'd0, c);
        m_op = op;
        add_cyc(rbit(), rbyte(), z, 3'd1, '0);
        if (op >= 4'd8 && TRAP_BUILD) begin
            c = '0;
            c[C_ILL] = 1'b1;
            for (int i = 0; i < 20; i++) add_cyc(rbit(), rbyte(), z, 3'd5, c);
            return;
        end
        c = '0;
        case (op)
            4'd0: begin c[C_SOUT] = 1'b1; c[C_INC] = 1'b1; end
            4'd1: begin c[C_INA] = 1'b1; c[C_SIN] = 1'b1; c[C_INC] = 1'b1; end
            4'd2: c[C_WM] = 1'b1;
            4'd3: c[C_RM] = 1'b1;
            4'd4: begin c[C_J] = 1'b1; c[C_LD] = 1'b1; end
            4'd5: begin c[C_JC] = 1'b1; if (z) c[C_LD] = 1'b1; else c[C_INC] = 1'b1; end
            4'd6: begin c[C_WR] = 1'b1; c[C_INC] = 1'b1; end
            4'd7: begin
                c[C_JC] = 1'b1; c[C_NEQ] = 1'b1;
                if (!z) c[C_LD] = 1'b1; else c[C_INC] = 1'b1;
            end
            default: begin c[C_INC] = 1'b1; c[C_ILL] = 1'b1; end
        endcase
        add_cyc(rbit(), rbyte(), z, 3'd2, c);
        if (op == 4'd2 || op == 4'd3) begin
            for (int unsigned i = 0; i <= mw; i++) begin
                c = '0;
                c[C_REQ] = 1'b1;
                c[C_WE]  = (op == 4'd2);
                c[C_WM]  = (op == 4'd2);
                c[C_RM]  = (op == 4'd3);
                if (i == mw && op == 4'd2) c[C_INC] = 1'b1;
                add_cyc(i == mw, rbyte(), z, 3'd3, c);
            end
            if (op == 4'd3) begin
                c = '0;
                c[C_WR] = 1'b1; c[C_RM] = 1'b1; c[C_INC] = 1'b1;
                add_cyc(rbit(), rbyte(), z, 3'd4, c);
            end
        end
    endfunction

    task automatic drive(input cyc_t r);
        @(negedge clk);
        mem_ack = r.ack;
        instr   = r.ins;
        zero    = r.z;
        #1;
    endtask

    // Reset for one edge with the given ack level, then release.
    task automatic do_reset(input logic ack);
        @(negedge clk);
        rst_n   = 1'b0;
        mem_ack = ack;
        instr   = rbyte();
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        #1;
        m_op = 4'd0;
    endtask

    task automatic test_reset();
        logic [21:0] got;
        logic [21:0] exp_rst;
        cyc_t r;
        int k = 0;
        exp_rst = {3'd0, 4'd0, 15'(1 << C_REQ)};
        do_reset(1'b0);
        got = obs();
        n_tests++;
        if (got !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_power_up: got %h expected %h", got, exp_rst);
        end
        model_idle(3);
        while (q.size() != 0) begin
            r = q.pop_front();
            drive(r);
            got = obs();
            n_tests++;
            if (got !== r.exp) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h expected %h", k, got, r.exp);
            end
            k++;
        end
        do_reset(1'b0);
        got = obs();
        n_tests++;
        if (got !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: got %h expected %h", got, exp_rst);
        end
    endtask

    task automatic test_r_zero_wait();
        logic [21:0] got;
        cyc_t r;
        int k = 0;
        model_instr(4'd0, rbit(), 0, 0);
        model_idle(1);
        while (q.size() != 0) begin
            r = q.pop_front();
            drive(r);
            got = obs();
            n_tests++;
            if (got !== r.exp) begin
                n_fail++;
                $display("FAIL r_zero_wait cyc %0d: got %h expected %h", k, got, r.exp);
            end
            k++;
        end
    endtask

    task automatic test_mr_wait();
        logic [21:0] got;
        cyc_t r;
        int k = 0;
        model_instr(4'd3, rbit(), 0, 2);
        model_idle(1);
        while (q.size() != 0) begin
            r = q.pop_front();
            drive(r);
            got = obs();
            n_tests++;
            if (got !== r.exp) begin
                n_fail++;
                $display("FAIL mr_wait cyc %0d: got %h expected %h", k, got, r.exp);
            end
            k++;
        end
    endtask

    task automatic test_branches();
        logic [21:0] got;
        cyc_t r;
        int k = 0;
        model_instr(4'd5, 1'b1, 0, 0);
        model_instr(4'd7, 1'b1, 1, 0);
        model_instr(4'd5, 1'b0, 0, 0);
        model_instr(4'd7, 1'b0, 2, 0);
        model_instr(4'd4, rbit(), 0, 0);
        model_idle(1);
        while (q.size() != 0) begin
            r = q.pop_front();
            drive(r);
            got = obs();
            n_tests++;
            if (got !== r.exp) begin
                n_fail++;
                $display("FAIL branches cyc %0d: got %h expected %h", k, got, r.exp);
            end
            k++;
        end
    endtask

    task automatic test_mw();
        logic [21:0] got;
        cyc_t r;
        int k = 0;
        model_instr(4'd2, rbit(), 0, 0);
        model_instr(4'd2, rbit(), 1, 3);
        model_idle(1);
        while (q.size() != 0) begin
            r = q.pop_front();
            drive(r);
            got = obs();
            n_tests++;
            if (got !== r.exp) begin
                n_fail++;
                $display("FAIL mw cyc %0d: got %h expected %h", k, got, r.exp);
            end
            k++;
        end
    endtask

    task automatic test_illegal();
        logic [21:0] got;
        logic [21:0] exp_rst;
        cyc_t r;
        int k = 0;
        exp_rst = {3'd0, 4'd0, 15'(1 << C_REQ)};
        model_instr(4'b1010, rbit(), 0, 0);
        if (!TRAP_BUILD) model_idle(1);
        while (q.size() != 0) begin
            r = q.pop_front();
            drive(r);
            got = obs();
            n_tests++;
            if (got !== r.exp) begin
                n_fail++;
                $display("FAIL illegal cyc %0d: got %h expected %h", k, got, r.exp);
            end
            k++;
        end
        do_reset(1'b1);
        got = obs();
        n_tests++;
        if (got !== exp_rst) begin
            n_fail++;
            $display("FAIL illegal_exit_reset: got %h expected %h", got, exp_rst);
        end
    endtask

    task automatic test_reset_mid_handshake();
        logic [21:0] got;
        logic [21:0] exp_rst;
        cyc_t r;
        int k = 0;
        exp_rst = {3'd0, 4'd0, 15'(1 << C_REQ)};
        model_instr(4'd3, rbit(), 0, 5);
        for (int i = 0; i < 4; i++) begin
            r = q.pop_front();
            drive(r);
            got = obs();
            n_tests++;
            if (got !== r.exp) begin
                n_fail++;
                $display("FAIL reset_mid_mem cyc %0d: got %h expected %h", k, got, r.exp);
            end
            k++;
        end
        q.delete();
        do_reset(1'b1);
        got = obs();
        n_tests++;
        if (got !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_mid_mem_state: got %h expected %h", got, exp_rst);
        end
    endtask

    task automatic test_random();
        logic [21:0] got;
        cyc_t r;
        int k = 0;
        int n_ret = 0;
        int n_instr = 40;
        for (int i = 0; i < n_instr; i++) begin
            model_instr(4'($urandom_range(0, TRAP_BUILD ? 7 : 15)), rbit(),
                        $urandom_range(0, 2), $urandom_range(0, 3));
        end
        model_idle(1);
        while (q.size() != 0) begin
            r = q.pop_front();
            drive(r);
            got = obs();
            if (pc_inc) n_ret++;
            if (pc_ld) n_ret++;
            n_tests++;
            if (got !== r.exp) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", k, got, r.exp);
            end
            k++;
        end
        n_tests++;
        if (n_ret !== n_instr) begin
            n_fail++;
            $display("FAIL random_retire_count: got %0d expected %0d", n_ret, n_instr);
        end
    endtask

    initial begin
        test_reset();
        test_r_zero_wait();
        test_mr_wait();
        test_branches();
        test_mw();
        test_illegal();
        test_reset_mid_handshake();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
